// File: rtl/cpu_bus_pkg.sv
// Shared types, address-map constants and region decode for the CPU memory bus.
// Latency: none (types and a pure combinational function).
// Backpressure: not applicable.
package cpu_bus_pkg;

   typedef enum logic [1:0] {
      REGION_RAM,
      REGION_PRG,
      REGION_OPEN
   } region_t;

   typedef enum logic [2:0] {
      IDLE,
      RAM_READ,
      PRG_WAIT,
      RESPOND,
      WRITE_HOLD
   } state_t;

   localparam logic [15:0] RAM_END  = 16'h1FFF;
   localparam logic [15:0] PRG_BASE = 16'h8000;

   // Work RAM mirrors across the low 8 KiB, ROM owns the top half, the rest floats.
   function automatic region_t decode_region(input logic [15:0] address);
      if (address <= RAM_END) begin
         return REGION_RAM;
      end else if (address >= PRG_BASE) begin
         return REGION_PRG;
      end else begin
         return REGION_OPEN;
      end
   endfunction

endpackage

// File: rtl/cpu_bus_if.sv
// CPU request/response and PRG-ROM read port bundle for the CPU memory bus.
// Latency: none (wires only).
// Backpressure: CPU holds address until cpu_data_valid_o; PRG read held until prg_data_valid_i.
interface cpu_bus_if;

   logic [15:0] cpu_address_i;
   logic        cpu_address_valid_i;
   logic [7:0]  cpu_data_i;
   logic        cpu_data_valid_i;
   logic [7:0]  cpu_data_o;
   logic        cpu_data_valid_o;
   logic [14:0] prg_address_o;
   logic        prg_read_o;
   logic [7:0]  prg_data_i;
   logic        prg_data_valid_i;

   // CPU core plus ROM side: drives requests and ROM acknowledges.
   modport master (
      output cpu_address_i, cpu_address_valid_i, cpu_data_i, cpu_data_valid_i,
      output prg_data_i, prg_data_valid_i,
      input  cpu_data_o, cpu_data_valid_o, prg_address_o, prg_read_o
   );

   // Bus decoder side.
   modport slave (
      input  cpu_address_i, cpu_address_valid_i, cpu_data_i, cpu_data_valid_i,
      input  prg_data_i, prg_data_valid_i,
      output cpu_data_o, cpu_data_valid_o, prg_address_o, prg_read_o
   );

endinterface

// File: rtl/cpu_ram.sv
// Single-port synchronous work RAM with write enable.
// Latency: read data registered, valid 1 cycle after the address is presented.
// Backpressure: none; accepts an access every cycle.
module cpu_ram #(
   parameter int RAM_ADDRESS_WIDTH = 11
) (
   input  logic                         clock,
   input  logic                         write_enable,
   input  logic [RAM_ADDRESS_WIDTH-1:0] address,
   input  logic [7:0]                   write_data,
   output logic [7:0]                   read_data
);

   logic [7:0] mem [2**RAM_ADDRESS_WIDTH];

   // Write when enabled; always register the addressed byte (old contents on a write cycle).
   always_ff @(posedge clock) begin
      if (write_enable) begin
         mem[address] <= write_data;
      end
      read_data <= mem[address];
   end

endmodule

// File: rtl/cpu_bus.sv
// CPU-side bus: decodes work RAM / PRG-ROM / open bus and returns read data with a valid.
// Latency: open bus 1 edge, RAM 2 edges, PRG ack edge + 1 (or timeout); writes complete at request edge.
// Backpressure: valid only while the CPU still presents the captured address; PRG read held until ack/timeout.
module cpu_bus
   import cpu_bus_pkg::*;
#(
   parameter int RAM_ADDRESS_WIDTH = 11,
   parameter int PRG_MIRROR_16K    = 1,
   parameter int PRG_TIMEOUT       = 255
) (
   input  logic     clock_i,
   input  logic     reset_i,
   cpu_bus_if.slave bus
);

   state_t      state;
   state_t      state_next;
   region_t     region;
   logic [15:0] req_address;
   logic [14:0] prg_address;
   logic [14:0] prg_target;
   logic        prg_read;
   logic [7:0]  data;
   logic [7:0]  open_bus;
   logic [7:0]  respond_byte;
   logic [7:0]  ram_read_data;
   logic        valid;
   logic [7:0]  timeout_count;
   logic        request;
   logic        write_request;
   logic        ram_write;
   logic        address_match;
   logic        timeout_hit;
   logic        enter_respond;

   // Decode straight from the live address so the request edge can already branch by region.
   assign region        = decode_region(bus.cpu_address_i);
   assign request       = (state == IDLE) && bus.cpu_address_valid_i;
   assign write_request = request && bus.cpu_data_valid_i;
   assign ram_write     = write_request && (region == REGION_RAM);
   assign address_match = (bus.cpu_address_i == req_address);
   assign timeout_hit   = (timeout_count >= 8'(PRG_TIMEOUT - 1));
   assign prg_target    = {(PRG_MIRROR_16K != 0) ? 1'b0 : bus.cpu_address_i[14],
                           bus.cpu_address_i[13:0]};
   assign enter_respond = (state != RESPOND) && (state_next == RESPOND);

   cpu_ram #(
      .RAM_ADDRESS_WIDTH(RAM_ADDRESS_WIDTH)
   ) u_ram (
      .clock       (clock_i),
      .write_enable(ram_write),
      .address     (bus.cpu_address_i[RAM_ADDRESS_WIDTH-1:0]),
      .write_data  (bus.cpu_data_i),
      .read_data   (ram_read_data)
   );

   // State register.
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state decode and selection of the byte handed back when entering RESPOND.
   always_comb begin
      state_next   = state;
      respond_byte = open_bus;
      case (state)
         IDLE: begin
            if (bus.cpu_address_valid_i) begin
               if (bus.cpu_data_valid_i) begin
                  state_next = WRITE_HOLD;
               end else begin
                  case (region)
                     REGION_RAM: state_next = RAM_READ;
                     REGION_PRG: state_next = PRG_WAIT;
                     default:    state_next = RESPOND;
                  endcase
               end
            end
         end
         RAM_READ: begin
            state_next   = RESPOND;
            respond_byte = ram_read_data;
         end
         PRG_WAIT: begin
            // The ROM transaction always finishes even if the CPU moved on; the valid gate hides it.
            if (bus.prg_data_valid_i) begin
               state_next   = RESPOND;
               respond_byte = bus.prg_data_i;
            end else if (timeout_hit) begin
               state_next = RESPOND;
            end
         end
         RESPOND: begin
            if (!(bus.cpu_address_valid_i && address_match)) begin
               state_next = IDLE;
            end
         end
         WRITE_HOLD: begin
            // Stay here while the strobe is held so a long strobe writes only once.
            if (!bus.cpu_data_valid_i || !address_match) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Request capture, PRG handshake, timeout counter, response data and open-bus latch.
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         req_address   <= '0;
         prg_address   <= '0;
         prg_read      <= 1'b0;
         timeout_count <= '0;
         data          <= '0;
         open_bus      <= '0;
         valid         <= 1'b0;
      end else begin
         if (request) begin
            req_address <= bus.cpu_address_i;
         end
         if (request && !bus.cpu_data_valid_i && (region == REGION_PRG)) begin
            prg_read      <= 1'b1;
            prg_address   <= prg_target;
            timeout_count <= '0;
         end else if (state == PRG_WAIT) begin
            if (bus.prg_data_valid_i || timeout_hit) begin
               prg_read <= 1'b0;
            end
            if (!bus.prg_data_valid_i && (timeout_count != 8'(PRG_TIMEOUT))) begin
               timeout_count <= timeout_count + 8'd1;
            end
         end
         if (enter_respond) begin
            data     <= respond_byte;
            open_bus <= respond_byte;
         end else if (write_request) begin
            open_bus <= bus.cpu_data_i;
         end
         valid <= (state_next == RESPOND);
      end
   end

   assign bus.cpu_data_o       = data;
   assign bus.cpu_data_valid_o = valid && bus.cpu_address_valid_i && address_match;
   assign bus.prg_address_o    = prg_address;
   assign bus.prg_read_o       = prg_read;

endmodule

// File: doc/cpu_bus.md
Name: cpu_bus

Overview:
- CPU-side memory bus directly downstream of the CPU core.
- Consumes the CPU's address, address-valid, write data and write strobe; returns read data with a data-valid handshake.
- Decodes the 6502 address map:
  - 2 KiB internal work RAM, mirrored through $0000-$1FFF.
  - PRG-ROM in $8000-$FFFF, read through an external variable-latency port.
  - Everything else is open bus.

Parameters:
- RAM_ADDRESS_WIDTH, 11, work RAM depth is 2**RAM_ADDRESS_WIDTH bytes; mirrored across $0000-$1FFF.
- PRG_MIRROR_16K, 1, when 1 prg_address_o[14] is forced to 0 (16 KiB ROM mirrored at $8000 and $C000).
- PRG_TIMEOUT, 255, cycles to wait for prg_data_valid_i before the read completes with the open-bus value.

Ports:
- clock_i  in  1  system clock.
- reset_i  in  1  reset.
- cpu_address_i  in  16  CPU address.
- cpu_address_valid_i  in  1  address is a live request.
- cpu_data_i  in  8  CPU write data.
- cpu_data_valid_i  in  1  write strobe (request is a write).
- cpu_data_o  out  8  read data.
- cpu_data_valid_o  out  1  cpu_data_o is valid for the current cpu_address_i.
- prg_address_o  out  15  PRG-ROM byte address.
- prg_read_o  out  1  PRG read request, held until acknowledged.
- prg_data_i  in  8  PRG read data.
- prg_data_valid_i  in  1  PRG read acknowledge; prg_data_i valid this cycle.

Behaviour:
- Clocking and reset:
  - Single clock, clock_i. Reset is synchronous and active-high on reset_i.
  - Reset values: state IDLE; cpu_data_o 0; cpu_data_valid_o 0; prg_read_o 0; prg_address_o 0; open-bus latch 0; timeout counter 0.
  - RAM contents are not reset.
  - reset_i mid-transaction returns to IDLE on that edge. A pending PRG read is dropped: prg_read_o is 0 after the edge.
- Regions:
  - RAM: $0000-$1FFF, index = address[RAM_ADDRESS_WIDTH-1:0].
  - PRG: $8000-$FFFF, prg_address_o = address[14:0], with bit 14 cleared when PRG_MIRROR_16K=1.
  - OPEN: $2000-$7FFF (PPU, APU and cart-RAM space are unimplemented here).
- States: IDLE, RAM_READ, PRG_WAIT, RESPOND, WRITE_HOLD.
- Request capture:
  - In IDLE, a request is sampled at edge E0 when cpu_address_valid_i=1.
  - The address is latched into req_address; the region is decoded from it.
- Read, RAM: E0 -> RAM_READ (synchronous RAM read issued); E1 -> RESPOND with the RAM byte. Latency 2 edges.
- Read, OPEN: E0 -> RESPOND with the open-bus latch value. Latency 1 edge.
- Read, PRG:
  - E0 -> PRG_WAIT with prg_read_o=1 and prg_address_o set.
  - On the edge where prg_data_valid_i=1: prg_read_o<=0, data captured, -> RESPOND.
  - If PRG_TIMEOUT cycles elapse with no acknowledge: prg_read_o<=0, -> RESPOND with the open-bus value.
  - prg_data_valid_i outside PRG_WAIT is ignored.
- Open-bus latch: updated with every byte returned in RESPOND and every byte written.
- RESPOND:
  - cpu_data_valid_o = registered valid AND (cpu_address_i == req_address) AND cpu_address_valid_i. The comparison is combinational, so the CPU never samples stale data.
  - Stays in RESPOND while the address is unchanged and valid.
  - On mismatch or valid low -> IDLE; the new request is sampled on the following IDLE edge.
- Address change during RAM_READ or PRG_WAIT:
  - The transaction completes internally: prg_read_o is held until acknowledge or timeout.
  - Then -> RESPOND; valid is gated off by the mismatch, so the FSM falls to IDLE and re-requests.
- Writes:
  - In IDLE with cpu_address_valid_i=1 and cpu_data_valid_i=1: RAM region is written at E0; other regions ignore the data.
  - The open-bus latch takes cpu_data_i. -> WRITE_HOLD; cpu_data_valid_o stays 0.
  - WRITE_HOLD -> IDLE when cpu_data_valid_i drops or the address changes. A held strobe therefore writes exactly once.
- Width rules: all address compares are 16-bit unsigned; the timeout counter is 8-bit and saturates at PRG_TIMEOUT.

Decomposition:
- cpu_bus_pkg holds:
  - the region_t enum (REGION_RAM, REGION_PRG, REGION_OPEN) and state_t;
  - constants RAM_END=16'h1FFF and PRG_BASE=16'h8000;
  - a pure function decode_region(address).
- One sub-module, cpu_ram: single-port synchronous RAM, parameterised by RAM_ADDRESS_WIDTH, with write-enable and a 1-cycle registered read.

Test Plan:
1. Reset: after reset_i is released -> cpu_data_valid_o=0, prg_read_o=0. Then write $5A to $0002 and read $0802 -> cpu_data_o=$5A, valid 2 edges after the request (mirroring).
2. PRG reset vector: request $FFFC; model acks after 3 cycles with $34 -> prg_address_o=$3FFC (16K mirror), cpu_data_o=$34, valid the edge after the ack. Then $FFFD returns $12.
3. Open bus: read $0000 returning $A7, then read $4000 -> cpu_data_o=$A7 with 1-edge latency. Write $3C to $6000, then read $2002 -> $3C; RAM is unchanged.
4. Address change mid-PRG-wait: request $8000, move the address to $0010 before the ack -> prg_read_o held until the ack. No valid is asserted for $8000; $0010 returns RAM data.
5. Timeout: with PRG_TIMEOUT=4 and no acknowledge -> prg_read_o drops after 4 cycles and cpu_data_o = the last open-bus value.
6. Held write strobe for 10 cycles to $0005 with data changing $11 -> $22 mid-strobe -> RAM[$005]=$11 (single write). Assert reset_i during PRG_WAIT -> prg_read_o=0 after that edge, FSM in IDLE.
